// File: rtl/redirect_ctrl.sv
// Redirect sequencer: on a retire-time mispredict from the ROB, pulse a single
// flush, stall dispatch while in-flight ALU/LSU work drains, then offer the
// corrected PC to fetch over a valid/ready handshake.
module redirect_ctrl #(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned DRAIN_MIN_CYCLES = 2,
    parameter int unsigned CNT_WIDTH        = 16
) (
    input  logic                  clk,
    input  logic                  rst_aL,
    input  logic                  rob_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] rob_redirect_pc,
    input  logic                  alu_busy,
    input  logic                  lsu_ld_inflight,
    input  logic                  fetch_redirect_ready,
    output logic                  flush,
    output logic                  dispatch_stall,
    output logic                  fetch_redirect_valid,
    output logic [ADDR_WIDTH-1:0] fetch_redirect_pc,
    output logic [CNT_WIDTH-1:0]  redirect_cnt,
    output logic                  redirect_overrun
);

    // Wide enough to hold DRAIN_MIN_CYCLES-1.
    localparam int unsigned DrainW =
        (DRAIN_MIN_CYCLES > 1) ? $clog2(DRAIN_MIN_CYCLES) : 1;
    localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_MIN_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StDrain,
        StRedirect
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DrainW-1:0]     drain_cnt_q, drain_cnt_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  overrun_q, overrun_d;

    logic drain_done;
    logic handshake;

    // Drain may end only once the minimum time has elapsed and both units are quiet.
    assign drain_done = (drain_cnt_q == '0) && !alu_busy && !lsu_ld_inflight;
    assign handshake  = fetch_redirect_valid && fetch_redirect_ready;

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            drain_cnt_q <= '0;
            cnt_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drain_cnt_q <= drain_cnt_d;
            cnt_q       <= cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state, PC capture, drain countdown and redirect bookkeeping.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drain_cnt_d = drain_cnt_q;
        cnt_d       = cnt_q;
        overrun_d   = overrun_q;

        case (state_q)
            StIdle: begin
                if (rob_redirect_valid) begin
                    pc_d    = rob_redirect_pc;
                    state_d = StFlush;
                end
            end
            StFlush: begin
                drain_cnt_d = DrainLoad;
                state_d     = StDrain;
            end
            StDrain: begin
                if (drain_cnt_q != '0) begin
                    drain_cnt_d = drain_cnt_q - DrainW'(1);
                end
                if (drain_done) begin
                    state_d = StRedirect;
                end
            end
            StRedirect: begin
                if (handshake) begin
                    state_d = StIdle;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The ROB is empty after a flush, so any redirect outside IDLE is a protocol
        // error; it is dropped (pc_q untouched above) and remembered until reset.
        if (rob_redirect_valid && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
    end

    // Outputs are pure decodes of registered state.
    always_comb begin
        flush                = (state_q == StFlush);
        dispatch_stall       = (state_q != StIdle);
        fetch_redirect_valid = (state_q == StRedirect);
        fetch_redirect_pc    = pc_q;
        redirect_cnt         = cnt_q;
        redirect_overrun     = overrun_q;
    end

endmodule

// File: doc/redirect_ctrl.md
Name: redirect_ctrl

Overview:
- Sequences pipeline recovery after the ROB signals a mispredicted branch or load at retire.
- Captures the redirect PC and pulses one flush to the RAT tables, ROB, IIQ, LSQ, ST_BUF speculative entries and the IFIFO.
- Stalls dispatch while in-flight ALU/LSU work drains, then hands the redirect to fetch with a valid/ready handshake.
- Sits between the ROB retire port and the fetch/dispatch boundary.

Parameters:
- ADDR_WIDTH, 32, PC width (matches addr_t).
- DRAIN_MIN_CYCLES, 2, minimum cycles spent in DRAIN. Must be at least 1.
- CNT_WIDTH, 16, width of the saturating redirect counter.

Ports:
- clk  input  1  clock
- rst_aL  input  1  asynchronous active-low reset
- rob_redirect_valid  input  1  ROB head retired with mispredict
- rob_redirect_pc  input  ADDR_WIDTH  correct next PC from the ROB
- alu_busy  input  1  ALU pipeline holds a valid instruction
- lsu_ld_inflight  input  1  load outstanding to dcache
- fetch_redirect_ready  input  1  fetch accepts the redirect this cycle
- flush  output  1  one-cycle flush pulse to RAT, ROB, IIQ, LSQ, ST_BUF and IFIFO
- dispatch_stall  output  1  forces dispatch to 0
- fetch_redirect_valid  output  1  redirect offered to fetch
- fetch_redirect_pc  output  ADDR_WIDTH  redirect target
- redirect_cnt  output  CNT_WIDTH  number of completed redirects, saturating
- redirect_overrun  output  1  sticky; a redirect arrived while not IDLE

Behaviour:
- Reset:
  - Asynchronous, active-low; applies immediately, including mid-sequence.
  - State=IDLE.
  - All outputs 0; fetch_redirect_pc=0; internal drain counter=0.
- States: IDLE, FLUSH, DRAIN, REDIRECT. The encoding is internal; outputs are decoded from the state register only.
- IDLE:
  - Outputs flush=0, stall=0.
  - On rob_redirect_valid: latch rob_redirect_pc into pc_q and go to FLUSH the next cycle.
- FLUSH (exactly 1 cycle):
  - flush=1, dispatch_stall=1.
  - Drain counter loads DRAIN_MIN_CYCLES-1.
  - Next state is DRAIN.
- DRAIN:
  - dispatch_stall=1, flush=0.
  - Counter decrements each cycle and saturates at 0.
  - Exit to REDIRECT when counter==0, alu_busy=0 and lsu_ld_inflight=0, all in the same cycle.
  - There is no timeout; DRAIN stalls indefinitely while busy.
- REDIRECT:
  - dispatch_stall=1, fetch_redirect_valid=1, fetch_redirect_pc=pc_q.
  - pc_q is held stable until the handshake completes.
  - When fetch_redirect_valid and fetch_redirect_ready are both 1: next state is IDLE, and redirect_cnt increments by 1, saturating at all-ones.
  - Without ready, the state is held and valid stays high with no drop.
- Latency:
  - rob_redirect_valid at cycle T gives flush=1 at T+1.
  - With drain inputs idle and fetch ready, fetch_redirect_valid is first high at T+1+DRAIN_MIN_CYCLES+1, and the handshake completes that same cycle.
  - dispatch_stall returns to 0 the cycle after the handshake.
- Simultaneous events:
  - rob_redirect_valid in FLUSH, DRAIN or REDIRECT is ignored: pc_q is not overwritten and redirect_overrun is set (sticky until reset).
  - rob_redirect_valid in the same cycle as REDIRECT→IDLE is also ignored and flags overrun; the ROB is empty after a flush, so this is a protocol error.
- fetch_redirect_ready outside REDIRECT has no effect.
- dispatch_stall is high in every non-IDLE state. It is low in IDLE even in the cycle rob_redirect_valid arrives; the ROB already blocks dispatch in that cycle.
- All outputs are registered state decodes, with no combinational path from inputs to outputs.

Test Plan:
1. Basic redirect:
   - Stimulus: reset; at cycle 5 rob_redirect_valid=1, pc=0x0000_1040; alu_busy=0, ld_inflight=0, ready=1.
   - Required: flush=1 only in cycle 6; stall high cycles 6–9; fetch_redirect_valid=1, pc=0x1040 in cycle 9; redirect_cnt=1; stall=0 in cycle 10.
2. Drain hold:
   - Stimulus: as scenario 1, but lsu_ld_inflight=1 through cycle 12.
   - Required: stays in DRAIN; fetch_redirect_valid first high in cycle 14; flush pulses exactly once.
3. Fetch backpressure:
   - Stimulus: ready=0 for 4 cycles in REDIRECT.
   - Required: valid and pc stable for all 4 cycles; completes on the first ready=1; cnt increments once.
4. Overrun:
   - Stimulus: second redirect with pc=0x2000 during DRAIN.
   - Required: redirect_overrun=1 (sticky); fetch_redirect_pc remains 0x1040; no second flush pulse.
5. Reset mid-sequence:
   - Stimulus: assert rst_aL=0 asynchronously during REDIRECT, between clock edges.
   - Required: all outputs go to 0 immediately; after release, state is IDLE and cnt=0.
6. Saturation:
   - Stimulus: CNT_WIDTH=2; 5 back-to-back redirects.
   - Required: redirect_cnt reads 1, 2, 3, 3, 3.
